// File: rtl/fpu_sequencer_pkg.sv
// Shared constants for the FPU issue/completion sequencer: op encodings,
// per-op pipeline latencies, FSM state encoding and the latency lookup.
package fpu_sequencer_pkg;

    localparam int unsigned OP_W  = 4;
    localparam int unsigned LAT_W = 5;

    // fpuOp encodings presented by EX
    localparam logic [OP_W-1:0] FOP_ADD    = 4'b0000;
    localparam logic [OP_W-1:0] FOP_SUB    = 4'b0001;
    localparam logic [OP_W-1:0] FOP_MUL    = 4'b0010;
    localparam logic [OP_W-1:0] FOP_DIV    = 4'b0011;
    localparam logic [OP_W-1:0] FOP_SGNJ   = 4'b0100;
    localparam logic [OP_W-1:0] FOP_MINMAX = 4'b0101;
    localparam logic [OP_W-1:0] FOP_SQRT   = 4'b0110;
    localparam logic [OP_W-1:0] FOP_CMP    = 4'b0111;
    localparam logic [OP_W-1:0] FOP_CVT_WS = 4'b1000;
    localparam logic [OP_W-1:0] FOP_CVT_SW = 4'b1001;

    // Cycles from issue-plus-one until the IP output is valid
    localparam logic [LAT_W-1:0] LAT_ADDSUB = 5'd7;
    localparam logic [LAT_W-1:0] LAT_MUL    = 5'd5;
    localparam logic [LAT_W-1:0] LAT_DIV    = 5'd6;
    localparam logic [LAT_W-1:0] LAT_SGNJ   = 5'd0;
    localparam logic [LAT_W-1:0] LAT_MINMAX = 5'd1;
    localparam logic [LAT_W-1:0] LAT_SQRT   = 5'd16;
    localparam logic [LAT_W-1:0] LAT_CMP    = 5'd1;
    localparam logic [LAT_W-1:0] LAT_CVT    = 5'd6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Returns {illegal, latency}; undefined ops complete immediately as illegal
    function automatic logic [LAT_W:0] fpu_lat(input logic [OP_W-1:0] op);
        case (op)
            FOP_ADD, FOP_SUB:       return {1'b0, LAT_ADDSUB};
            FOP_MUL:                return {1'b0, LAT_MUL};
            FOP_DIV:                return {1'b0, LAT_DIV};
            FOP_SGNJ:               return {1'b0, LAT_SGNJ};
            FOP_MINMAX:             return {1'b0, LAT_MINMAX};
            FOP_SQRT:               return {1'b0, LAT_SQRT};
            FOP_CMP:                return {1'b0, LAT_CMP};
            FOP_CVT_WS, FOP_CVT_SW: return {1'b0, LAT_CVT};
            default:                return {1'b1, 5'd0};
        endcase
    endfunction

endpackage

// File: rtl/fpu_sequencer_if.sv
// Request (EX -> sequencer) and writeback (sequencer -> WB) handshake bundle.
interface fpu_sequencer_if #(
    parameter int unsigned WIDTH = 32
);
    logic             req_valid;
    logic             req_ready;
    logic [3:0]       req_op;
    logic [2:0]       req_func3;
    logic             req_rs1_0;
    logic [4:0]       req_rd;
    logic [WIDTH-1:0] req_a;
    logic [WIDTH-1:0] req_b;

    logic             wb_valid;
    logic             wb_ready;
    logic [4:0]       wb_rd;
    logic [WIDTH-1:0] wb_data;
    logic             wb_illegal;

    // Pipeline side: issues ops and consumes results
    modport master (
        output req_valid, req_op, req_func3, req_rs1_0, req_rd, req_a, req_b, wb_ready,
        input  req_ready, wb_valid, wb_rd, wb_data, wb_illegal
    );

    // Sequencer side
    modport slave (
        input  req_valid, req_op, req_func3, req_rs1_0, req_rd, req_a, req_b, wb_ready,
        output req_ready, wb_valid, wb_rd, wb_data, wb_illegal
    );
endinterface

// File: rtl/fpu_sequencer_latency_lut.sv
// Combinational fpuOp -> pipeline latency / illegal-op decode.
module fpu_sequencer_latency_lut
    import fpu_sequencer_pkg::*;
(
    input  logic [OP_W-1:0]  op,
    output logic [LAT_W-1:0] lat,
    output logic             illegal
);

    // Table lookup shared with any other user of the package function
    always_comb begin
        {illegal, lat} = fpu_lat(op);
    end

endmodule

// File: rtl/fpu_sequencer.sv
// Issue/completion controller in front of the FPU datapath. Accepts one op,
// freezes its operands, waits the op's pipeline latency, captures the result
// and holds it for writeback. Only one op is ever in flight.
module fpu_sequencer
    import fpu_sequencer_pkg::*;
#(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned CNT_W   = 5,
    parameter int unsigned MAX_LAT = 16
) (
    input  logic             clock,
    input  logic             reset,
    fpu_sequencer_if.slave   bus,
    input  logic             kill,
    output logic [3:0]       fpu_op,
    output logic [2:0]       fpu_func3,
    output logic             fpu_rs1_0,
    output logic [WIDTH-1:0] fpu_a,
    output logic [WIDTH-1:0] fpu_b,
    input  logic [WIDTH-1:0] fpu_result,
    output logic             busy
);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [CNT_W-1:0]   lat_q;
    logic               illegal_q;
    logic [4:0]         tag_q;
    logic [WIDTH-1:0]   wb_data_q;
    logic               wb_illegal_q;
    logic [LAT_W-1:0]   lut_lat;
    logic               lut_illegal;
    logic               accept;
    logic               capture;

    fpu_sequencer_latency_lut u_lut (
        .op      (bus.req_op),
        .lat     (lut_lat),
        .illegal (lut_illegal)
    );

    // Handshake and stall; busy covers the accept cycle so EX stalls immediately
    always_comb begin
        bus.req_ready  = (state_q == ST_IDLE) && !kill && !reset;
        accept         = bus.req_valid && bus.req_ready;
        busy           = (state_q != ST_IDLE) || accept;
        bus.wb_valid   = (state_q == ST_DONE);
        bus.wb_rd      = tag_q;
        bus.wb_data    = wb_data_q;
        bus.wb_illegal = wb_illegal_q;
    end

    // Next-state, latency counter and capture strobe; kill overrides everything
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        capture = 1'b0;
        if (kill) begin
            state_d = ST_IDLE;
            count_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        state_d = ST_BUSY;
                        count_d = '0;
                    end
                end
                ST_BUSY: begin
                    // Counter parks at the latency rather than wrapping
                    if (count_q == lat_q) begin
                        capture = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        count_d = count_q + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    if (bus.wb_ready) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // FSM state and counter registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    // Operand freeze on accept, result capture at end of latency
    always_ff @(posedge clock) begin
        if (reset) begin
            fpu_op       <= '0;
            fpu_func3    <= '0;
            fpu_rs1_0    <= 1'b0;
            fpu_a        <= '0;
            fpu_b        <= '0;
            tag_q        <= '0;
            lat_q        <= '0;
            illegal_q    <= 1'b0;
            wb_data_q    <= '0;
            wb_illegal_q <= 1'b0;
        end else begin
            if (accept) begin
                fpu_op    <= bus.req_op;
                fpu_func3 <= bus.req_func3;
                fpu_rs1_0 <= bus.req_rs1_0;
                fpu_a     <= bus.req_a;
                fpu_b     <= bus.req_b;
                tag_q     <= bus.req_rd;
                lat_q     <= CNT_W'(lut_lat);
                illegal_q <= lut_illegal;
            end
            if (capture) begin
                wb_data_q    <= illegal_q ? '0 : fpu_result;
                wb_illegal_q <= illegal_q;
            end
        end
    end

    // Latched latency must fit the counter and never exceed the slowest op
    assert property (@(posedge clock) disable iff (reset) lat_q <= CNT_W'(MAX_LAT));
    assert property (@(posedge clock) disable iff (reset) count_q <= lat_q);

endmodule
